// File: rtl/tick_timer_sched.sv
// tick_timer_sched: us/ms/s tick cascade shared by four one-shot/periodic timer channels; SCHED_PAUSE_EN adds a pause input
module tick_timer_sched #(
  parameter int CLK_DIV_US = 12,
  parameter int TIMER_W    = 16
) (
  input  logic               clk_in,
  input  logic               rst,
`ifdef SCHED_PAUSE_EN
  input  logic               pause,
`endif
  output logic               tick_us,
  output logic               tick_ms,
  output logic               tick_s,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [1:0]         cfg_ch,
  input  logic               cfg_cmd,
  input  logic [1:0]         cfg_base,
  input  logic               cfg_mode,
  input  logic [TIMER_W-1:0] cfg_period,
  output logic [3:0]         ch_busy,
  output logic [3:0]         ch_expire
);
  typedef enum logic {IDLE, RUN} state_e;
  localparam int UW = $clog2(CLK_DIV_US);
  logic hold;
`ifdef SCHED_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif
  logic [UW-1:0] us_cnt_q, us_cnt_d;
  logic [9:0] ms_cnt_q, ms_cnt_d, s_cnt_q, s_cnt_d;
  logic tick_us_q, tick_us_d, tick_ms_q, tick_ms_d, tick_s_q, tick_s_d, cfg_ready_q;
  logic us_wrap, ms_wrap, s_wrap, accept;
  state_e state_q [4];
  state_e state_d [4];
  logic [1:0] base_q [4];
  logic [1:0] base_d [4];
  logic mode_q [4];
  logic mode_d [4];
  logic [TIMER_W-1:0] period_q [4];
  logic [TIMER_W-1:0] period_d [4];
  logic [TIMER_W-1:0] cnt_q [4];
  logic [TIMER_W-1:0] cnt_d [4];
  logic [3:0] expire_q, expire_d, base_tick;
  assign accept  = cfg_valid && cfg_ready_q;
  assign us_wrap = us_cnt_q == UW'(CLK_DIV_US - 1);
  assign ms_wrap = us_wrap && ms_cnt_q == 10'd999;
  assign s_wrap  = ms_wrap && s_cnt_q == 10'd999;
  assign cfg_ready = cfg_ready_q;
  assign tick_us   = tick_us_q && !hold;
  assign tick_ms   = tick_ms_q && !hold;
  assign tick_s    = tick_s_q && !hold;
  assign ch_expire = expire_q & {4{!hold}};
  // prescaler cascade next state; a pause freezes counters and pending ticks alike
  always_comb begin
    us_cnt_d  = hold ? us_cnt_q : us_wrap ? '0 : us_cnt_q + 1'b1;
    ms_cnt_d  = (hold || !us_wrap) ? ms_cnt_q : ms_wrap ? '0 : ms_cnt_q + 10'd1;
    s_cnt_d   = (hold || !ms_wrap) ? s_cnt_q : s_wrap ? '0 : s_cnt_q + 10'd1;
    tick_us_d = hold ? tick_us_q : us_wrap;
    tick_ms_d = hold ? tick_ms_q : ms_wrap;
    tick_s_d  = hold ? tick_s_q : s_wrap;
  end
  // channel FSMs: an accepted command takes priority over a same-cycle count or expiry
  always_comb begin
    ch_busy   = '0;
    base_tick = '0;
    expire_d  = '0;
    for (int i = 0; i < 4; i++) begin
      state_d[i]   = state_q[i];
      base_d[i]    = base_q[i];
      mode_d[i]    = mode_q[i];
      period_d[i]  = period_q[i];
      cnt_d[i]     = cnt_q[i];
      ch_busy[i]   = state_q[i] == RUN;
      expire_d[i]  = hold ? expire_q[i] : 1'b0;
      base_tick[i] = !hold && (base_q[i] == 2'b00 ? tick_us_q :
                               base_q[i] == 2'b01 ? tick_ms_q :
                               base_q[i] == 2'b10 ? tick_s_q : 1'b1);
      if (accept && cfg_ch == 2'(i)) begin
        if (cfg_cmd && cfg_period != '0) begin
          state_d[i]  = RUN;
          base_d[i]   = cfg_base;
          mode_d[i]   = cfg_mode;
          period_d[i] = cfg_period;
          cnt_d[i]    = cfg_period - 1'b1;
        end else begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      end else if (state_q[i] == RUN && base_tick[i]) begin
        if (cnt_q[i] != '0) begin
          cnt_d[i] = cnt_q[i] - 1'b1;
        end else begin
          expire_d[i] = 1'b1;
          cnt_d[i]    = mode_q[i] ? period_q[i] - 1'b1 : '0;
          state_d[i]  = mode_q[i] ? RUN : IDLE;
        end
      end
    end
  end
  // state registers; reset clears every counter, tick and in-flight expiry immediately
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      us_cnt_q    <= '0;
      ms_cnt_q    <= '0;
      s_cnt_q     <= '0;
      tick_us_q   <= 1'b0;
      tick_ms_q   <= 1'b0;
      tick_s_q    <= 1'b0;
      cfg_ready_q <= 1'b0;
      state_q     <= '{default: IDLE};
      base_q      <= '{default: '0};
      mode_q      <= '{default: 1'b0};
      period_q    <= '{default: '0};
      cnt_q       <= '{default: '0};
      expire_q    <= '0;
    end else begin
      us_cnt_q    <= us_cnt_d;
      ms_cnt_q    <= ms_cnt_d;
      s_cnt_q     <= s_cnt_d;
      tick_us_q   <= tick_us_d;
      tick_ms_q   <= tick_ms_d;
      tick_s_q    <= tick_s_d;
      cfg_ready_q <= 1'b1;
      state_q     <= state_d;
      base_q      <= base_d;
      mode_q      <= mode_d;
      period_q    <= period_d;
      cnt_q       <= cnt_d;
      expire_q    <= expire_d;
    end
  end
endmodule

// File: tb/tb_tick_timer_sched.sv
// tb_tick_timer_sched: directed checks of the tick cascade and timer channels with CLK_DIV_US=4
module tb_tick_timer_sched;
  logic clk = 1'b0, rst = 1'b0;
  logic cfg_valid = 1'b0, cfg_cmd = 1'b0, cfg_mode = 1'b0;
  logic [1:0] cfg_ch = '0, cfg_base = '0;
  logic [15:0] cfg_period = '0;
  logic tick_us, tick_ms, tick_s, cfg_ready;
  logic [3:0] ch_busy, ch_expire;
  int vecs = 0, miss = 0, cyc = 0, t0 = 0;
`ifdef SCHED_PAUSE_EN
  logic pause = 1'b0;
`endif
  tick_timer_sched #(.CLK_DIV_US(4), .TIMER_W(16)) dut (
    .clk_in(clk), .rst(rst),
`ifdef SCHED_PAUSE_EN
    .pause(pause),
`endif
    .tick_us(tick_us), .tick_ms(tick_ms), .tick_s(tick_s),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_cmd(cfg_cmd),
    .cfg_base(cfg_base), .cfg_mode(cfg_mode), .cfg_period(cfg_period),
    .ch_busy(ch_busy), .ch_expire(ch_expire));
  always #5 clk = ~clk;
  always @(posedge clk or negedge rst) cyc <= !rst ? 0 : cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cmd(input logic [1:0] ch, input logic c, input logic [1:0] b, input logic m, input logic [15:0] p);
    cfg_valid = 1'b1; cfg_ch = ch; cfg_cmd = c; cfg_base = b; cfg_mode = m; cfg_period = p;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", {tick_us, tick_ms, tick_s, cfg_ready, ch_busy, ch_expire}, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_release", cfg_ready, 1);
    chk("tick_us_c1", tick_us, 0);
    for (int k = 2; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("tick_us_c%0d", k), tick_us, (k % 4 == 0));
    end
    while (cyc < 3999) @(negedge clk);
    chk("tick_ms_c3999", {tick_us, tick_ms}, 2'b00);
    @(negedge clk);
    chk("tick_ms_c4000", {tick_us, tick_ms, tick_s}, 3'b110);
    @(negedge clk);
    chk("tick_ms_c4001", {tick_us, tick_ms}, 2'b00);
    // ch0 raw base, period 5, one-shot
    cmd(2'd0, 1'b1, 2'b11, 1'b0, 16'd5);
    chk("oneshot_d0", {ch_busy, ch_expire}, 8'h10);
    for (int d = 1; d <= 6; d++) begin
      @(negedge clk);
      chk($sformatf("oneshot_d%0d", d), {ch_busy, ch_expire}, d < 5 ? 8'h10 : d == 5 ? 8'h01 : 8'h00);
    end
    // ch1 us base, period 3, periodic: accept on an edge two cycles past a tick_us edge
    while (cyc % 4 != 1) @(negedge clk);
    cmd(2'd1, 1'b1, 2'b00, 1'b1, 16'd3);
    t0 = cyc;
    for (int d = 1; d <= 39; d++) begin
      @(negedge clk);
      chk($sformatf("periodic_d%0d", d), {ch_busy, ch_expire}, (d == 11 || d == 23 || d == 35) ? 8'h22 : 8'h20);
    end
    cmd(2'd1, 1'b0, 2'b00, 1'b0, 16'd0);
    for (int d = 0; d < 16; d++) begin
      if (d > 0) @(negedge clk);
      chk($sformatf("periodic_stopped_%0d", d), {ch_busy, ch_expire}, 8'h00);
    end
    // period 0 start on a running ch2 acts as stop
    cmd(2'd2, 1'b1, 2'b11, 1'b1, 16'd4);
    repeat (2) @(negedge clk);
    chk("ch2_running", {ch_busy, ch_expire}, 8'h40);
    cmd(2'd2, 1'b1, 2'b11, 1'b1, 16'd0);
    for (int d = 0; d < 8; d++) begin
      if (d > 0) @(negedge clk);
      chk($sformatf("ch2_period0_%0d", d), {ch_busy, ch_expire}, 8'h00);
    end
    // restart ch3 mid-count: period 8 discarded, period 2 wins
    cmd(2'd3, 1'b1, 2'b11, 1'b0, 16'd8);
    repeat (3) @(negedge clk);
    cmd(2'd3, 1'b1, 2'b11, 1'b0, 16'd2);
    for (int d = 1; d <= 8; d++) begin
      @(negedge clk);
      chk($sformatf("restart_d%0d", d), {ch_busy, ch_expire}, d == 1 ? 8'h80 : d == 2 ? 8'h08 : 8'h00);
    end
    // stop lands on ch0's would-be expiry edge
    cmd(2'd0, 1'b1, 2'b11, 1'b0, 16'd5);
    repeat (4) @(negedge clk);
    chk("stop_race_pre", {ch_busy, ch_expire}, 8'h10);
    cmd(2'd0, 1'b0, 2'b11, 1'b0, 16'd5);
    for (int d = 0; d < 3; d++) begin
      if (d > 0) @(negedge clk);
      chk($sformatf("stop_race_%0d", d), {ch_busy, ch_expire}, 8'h00);
    end
    // ch1 and ch2 identical us-base one-shots started on consecutive edges expire together
    while (cyc % 4 != 1) @(negedge clk);
    cmd(2'd1, 1'b1, 2'b00, 1'b0, 16'd2);
    cmd(2'd2, 1'b1, 2'b00, 1'b0, 16'd2);
    for (int d = 2; d <= 8; d++) begin
      @(negedge clk);
      chk($sformatf("dual_d%0d", d), {ch_busy, ch_expire}, d < 7 ? 8'h60 : d == 7 ? 8'h06 : 8'h00);
    end
`ifdef SCHED_PAUSE_EN
    // 7-cycle pause inside a raw period of 10 pushes the expiry from T+10 to T+17
    cmd(2'd0, 1'b1, 2'b11, 1'b0, 16'd10);
    repeat (3) @(negedge clk);
    pause = 1'b1;
    for (int d = 4; d <= 10; d++) begin
      @(negedge clk);
      chk($sformatf("paused_d%0d", d), {tick_us, tick_ms, ch_busy, ch_expire}, 10'h010);
    end
    pause = 1'b0;
    for (int d = 11; d <= 18; d++) begin
      @(negedge clk);
      chk($sformatf("pause_resume_d%0d", d), {ch_busy, ch_expire}, d < 17 ? 8'h10 : d == 17 ? 8'h01 : 8'h00);
    end
`endif
    // asynchronous reset in the middle of a periodic run
    cmd(2'd1, 1'b1, 2'b11, 1'b1, 16'd20);
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", ch_busy, 4'b0010);
    #2 rst = 1'b0;
    #1 chk("async_reset", {tick_us, tick_ms, tick_s, cfg_ready, ch_busy, ch_expire}, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("rerelease_c%0d", k), {tick_us, ch_busy}, k == 4 ? 5'h10 : 5'h00);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
